// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared key-length encodings, FSM states and Nk/Nr lookups for the AES key schedule
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;
    localparam logic [1:0] KEY_LEN_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ke_state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nk_of = 4'd4;
            KEY_LEN_192: nk_of = 4'd6;
            default:     nk_of = 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nr_of = 4'd10;
            KEY_LEN_192: nr_of = 4'd12;
            default:     nr_of = 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    assign base     = 11'd2047 - {in_byte, 3'b000};
    assign out_byte = SBOX_TABLE[base -: 8];

endmodule

// File: rtl/key_word_sub.sv
// rtl/key_word_sub.sv - combinational t-generator: optional RotWord, SubWord and Rcon injection
module key_word_sub
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic        rot_en,
    input  logic        sub_en,
    input  logic        rcon_en,
    input  logic [7:0]  rcon,
    output logic [31:0] t_out
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;

    assign rot_word = rot_en ? {word_in[23:0], word_in[31:24]} : word_in;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        t_out = word_in;
        if (sub_en) begin
            t_out = sub_word ^ {(rcon_en ? rcon : 8'h00), 24'h000000};
        end
    end

endmodule

// File: rtl/key_expander.sv
// rtl/key_expander.sv - streaming AES-128/192/256 key schedule, one word per accepted handshake
module key_expander
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       keyLen,
    input  logic [255:0]     keyIn,
    output logic             busy,
    output logic             wordValid,
    input  logic             wordReady,
    output logic [31:0]      wordOut,
    output logic [IDX_W-1:0] wordIdx,
    output logic             done,
    output logic             err
);

    localparam int WIN_AW = (MAX_NK > 1) ? $clog2(MAX_NK) : 1;

    ke_state_e        state_q, state_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [2:0]       mod_q, mod_d;
    logic [3:0]       nk_q, nk_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [31:0]      win_q [MAX_NK];
    logic [31:0]      win_d [MAX_NK];

    logic [31:0]      key_words [8];
    logic [3:0]       start_nk;
    logic             start_legal;
    logic             accept;
    logic [IDX_W-1:0] next_idx;
    logic [2:0]       next_mod;
    logic             rot_sel;
    logic             sub_sel;
    logic [31:0]      oldest_word;
    logic [31:0]      t_word;

    for (genvar k = 0; k < 8; k++) begin : g_key
        assign key_words[k] = keyIn[255-32*k -: 32];
    end

    assign start_nk    = nk_of(keyLen);
    assign start_legal = (keyLen != KEY_LEN_BAD) && (int'(start_nk) <= MAX_NK);
    assign accept      = valid_q && wordReady;
    assign next_idx    = idx_q + IDX_W'(1);
    assign next_mod    = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
    assign rot_sel     = (next_mod == 3'd0);
    assign sub_sel     = rot_sel || ((nk_q == 4'd8) && (next_mod == 3'd4));

    // The window is top-aligned: newest word always at MAX_NK-1, w[i-Nk] at MAX_NK-Nk.
    assign oldest_word = win_q[WIN_AW'(MAX_NK - int'(nk_q))];

    key_word_sub u_sub (
        .word_in (win_q[MAX_NK-1]),
        .rot_en  (rot_sel),
        .sub_en  (sub_sel),
        .rcon_en (rot_sel),
        .rcon    (rcon_q),
        .t_out   (t_word)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        word_d  = word_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mod_d   = mod_q;
        nk_d    = nk_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (start && start_legal) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    nk_d    = start_nk;
                    last_d  = IDX_W'({nr_of(keyLen), 2'b11});
                    word_d  = key_words[0];
                    idx_d   = '0;
                    mod_d   = '0;
                    rcon_d  = 8'h01;
                    for (int p = 0; p < MAX_NK; p++) begin
                        if (p >= MAX_NK - int'(start_nk)) begin
                            win_d[p] = key_words[3'(p - (MAX_NK - int'(start_nk)))];
                        end
                    end
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = next_idx;
                        mod_d = next_mod;
                        if (next_idx < IDX_W'(nk_q)) begin
                            word_d = win_q[WIN_AW'(MAX_NK - int'(nk_q) + int'(next_idx))];
                        end else begin
                            word_d = oldest_word ^ t_word;
                            for (int p = 0; p < MAX_NK - 1; p++) begin
                                win_d[p] = win_q[p+1];
                            end
                            win_d[MAX_NK-1] = oldest_word ^ t_word;
                        end
                        if ((mod_q == 3'd0) && (idx_q >= IDX_W'(nk_q))) begin
                            rcon_d = xtime(rcon_q);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            mod_q   <= '0;
            nk_q    <= '0;
            rcon_q  <= 8'h01;
            for (int p = 0; p < MAX_NK; p++) begin
                win_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            mod_q   <= mod_d;
            nk_q    <= nk_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
        end
    end

    assign busy      = busy_q;
    assign wordValid = valid_q;
    assign wordOut   = word_q;
    assign wordIdx   = idx_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - self-checking bench for key_expander with an independent key-schedule model
module tb_key_expander;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct packed {
        logic [31:0] word;
        logic [5:0]  idx;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start, start6;
    logic [1:0]   keyLen, keyLen6;
    logic [255:0] keyIn, keyIn6;
    logic         wordReady, wordReady6;
    logic         busy, busy6;
    logic         wordValid, wordValid6;
    logic [31:0]  wordOut, wordOut6;
    logic [5:0]   wordIdx, wordIdx6;
    logic         done, done6;
    logic         err, err6;

    exp_t         exp_q [$];
    logic [31:0]  got [64];
    int           n_cmp = 0;
    int           n_fail = 0;
    bit           done_seen;

    key_expander #(.MAX_NK(8), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .keyLen(keyLen), .keyIn(keyIn),
        .busy(busy), .wordValid(wordValid), .wordReady(wordReady), .wordOut(wordOut),
        .wordIdx(wordIdx), .done(done), .err(err)
    );

    key_expander #(.MAX_NK(6), .IDX_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .keyLen(keyLen6), .keyIn(keyIn6),
        .busy(busy6), .wordValid(wordValid6), .wordReady(wordReady6), .wordOut(wordOut6),
        .wordIdx(wordIdx6), .done(done6), .err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        logic [7:0] r;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic push_schedule(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          total = 4 * (nk + 7);
        exp_q.delete();
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            exp_q.push_back('{word: w[i], idx: 6'(i)});
        end
    endtask

    task automatic do_start(input logic [255:0] key, input logic [1:0] len, input bit hold_start);
        @(negedge clk);
        keyIn  = key;
        keyLen = len;
        start  = 1'b1;
        @(negedge clk);
        start  = hold_start;
        keyIn  = ~key;
        keyLen = 2'd3;
        check("latency_valid", 32'(wordValid), 32'd1);
        check("latency_idx", 32'(wordIdx), 32'd0);
        check("latency_busy", 32'(busy), 32'd1);
    endtask

    task automatic drain(input bit rnd, input int stop_after, input int total);
        int          cycles = 0;
        int          n_acc = 0;
        bit          held = 1'b0;
        bit          err_seen = 1'b0;
        bit          r;
        logic [31:0] hw;
        logic [5:0]  hi;
        exp_t        e;
        foreach (got[i]) got[i] = 'x;
        while (exp_q.size() > 0 && n_acc < stop_after && cycles < 4000) begin
            if (err) err_seen = 1'b1;
            if (held) begin
                check("stall_valid", 32'(wordValid), 32'd1);
                check("stall_word", wordOut, hw);
                check("stall_idx", 32'(wordIdx), 32'(hi));
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wordReady = r;
            held = 1'b0;
            if (wordValid) begin
                if (r) begin
                    e = exp_q.pop_front();
                    check($sformatf("word[%0d]", e.idx), wordOut, e.word);
                    check($sformatf("idx[%0d]", e.idx), 32'(wordIdx), 32'(e.idx));
                    got[wordIdx] = wordOut;
                    n_acc++;
                end else begin
                    held = 1'b1;
                    hw = wordOut;
                    hi = wordIdx;
                end
            end
            @(negedge clk);
            cycles++;
        end
        wordReady = 1'b0;
        check("words_accepted", 32'(n_acc), 32'((stop_after < total) ? stop_after : total));
        check("no_err_while_busy", 32'(err_seen), 32'd0);
    endtask

    task automatic run_full(input logic [255:0] key, input logic [1:0] len, input int nk,
                            input bit rnd, input bit hold_start);
        push_schedule(key, nk);
        do_start(key, len, hold_start);
        drain(rnd, 1000, 4 * (nk + 7));
        start = 1'b0;
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_valid", 32'(wordValid), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(wordValid), 32'd0);
        check("idle_err", 32'(err), 32'd0);
    endtask

    initial begin
        start = 1'b0; keyLen = 2'd0; keyIn = '0; wordReady = 1'b0;
        start6 = 1'b0; keyLen6 = 2'd0; keyIn6 = '0; wordReady6 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(wordValid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word", wordOut, 32'd0);
        check("rst_idx", 32'(wordIdx), 32'd0);
        check("rst6_busy", 32'(busy6), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_full(K128, 2'd0, 4, 1'b0, 1'b0);
        check("aes128_w4", got[4], 32'ha0fafe17);
        check("aes128_w43", got[43], 32'hb6630ca6);

        // start held high with an illegal keyLen throughout the run must be ignored
        run_full(K192, 2'd1, 6, 1'b0, 1'b1);
        check("aes192_w6", got[6], 32'hfe0c91f7);
        check("aes192_w51", got[51], 32'h01002202);

        run_full(K256, 2'd2, 8, 1'b1, 1'b0);
        check("aes256_w8", got[8], 32'h9ba35411);
        check("aes256_w59", got[59], 32'h706c631e);

        @(negedge clk);
        start = 1'b1; keyLen = 2'd3; keyIn = K128;
        @(negedge clk);
        start = 1'b0;
        check("bad_len_err", 32'(err), 32'd1);
        check("bad_len_busy", 32'(busy), 32'd0);
        check("bad_len_valid", 32'(wordValid), 32'd0);
        @(negedge clk);
        check("bad_len_err_pulse", 32'(err), 32'd0);

        start6 = 1'b1; keyLen6 = 2'd2; keyIn6 = K256;
        @(negedge clk);
        start6 = 1'b0;
        check("nk_over_max_err", 32'(err6), 32'd1);
        check("nk_over_max_busy", 32'(busy6), 32'd0);
        check("nk_over_max_valid", 32'(wordValid6), 32'd0);
        @(negedge clk);
        check("nk_over_max_err_pulse", 32'(err6), 32'd0);

        push_schedule(K128, 4);
        do_start(K128, 2'd0, 1'b0);
        drain(1'b0, 20, 44);
        check("pre_reset_idx", 32'(wordIdx), 32'd20);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(wordValid), 32'd0);
        check("midrst_word", wordOut, 32'd0);
        check("midrst_idx", 32'(wordIdx), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        check("post_rst_valid", 32'(wordValid), 32'd0);

        run_full(K128, 2'd0, 4, 1'b0, 1'b0);
        check("restart_w0", got[0], 32'h2b7e1516);
        check("restart_w43", got[43], 32'hb6630ca6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
